// File: rtl/audio_cfg_pkg.sv
// Shared types and reset defaults for the audio configuration controller.
// Command layout, address map, receiver states and readback formatting.
package audio_cfg_pkg;

    typedef enum logic [2:0] {
        ADDR_VOLUME  = 3'd0,
        ADDR_EFFECT  = 3'd1,
        ADDR_CONTROL = 3'd2,
        ADDR_COMMIT  = 3'd3,
        ADDR_ERR_CLR = 3'd4,
        ADDR_RSVD5   = 3'd5,
        ADDR_RSVD6   = 3'd6,
        ADDR_STATUS  = 3'd7
    } cfg_addr_e;

    typedef struct packed {
        logic        rw;
        cfg_addr_e   addr;
        logic [11:0] data;
    } cfg_cmd_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_EXEC,
        RX_DONE
    } rx_state_e;

    localparam logic [7:0] VOLUME_DEFAULT = 8'h80;
    localparam logic [2:0] EFFECT_DEFAULT = 3'd0;
    localparam logic       MUTE_DEFAULT   = 1'b1;
    localparam logic       BYPASS_DEFAULT = 1'b1;

    function automatic logic [15:0] readback_value(
        input cfg_addr_e  addr,
        input logic [7:0] vol,
        input logic [2:0] eff,
        input logic       mute,
        input logic       bypass,
        input logic [2:0] status
    );
        logic [15:0] v;
        v = 16'h0000;
        case (addr)
            ADDR_VOLUME:  v = {8'h00, vol};
            ADDR_EFFECT:  v = {13'h0000, eff};
            ADDR_CONTROL: v = {14'h0000, bypass, mute};
            ADDR_STATUS:  v = {13'h0000, status};
            default:      v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/audio_config_controller_rx.sv
// SPI command word receiver: shifts MSB-first words while chip select is low,
// strobes a completed word for one cycle and flags short or overlong frames.
module spi_word_receiver
    import audio_cfg_pkg::*;
#(
    parameter int WORD_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cs_n_i,
    input  logic                 mosi_i,
    output logic [WORD_BITS-1:0] word_o,
    output logic                 word_valid_o,
    output logic                 bit_strobe_o,
    output logic                 err_short_o,
    output logic                 err_overrun_o
);

    localparam int CW = $clog2(WORD_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        word_valid_o  = 1'b0;
        bit_strobe_o  = 1'b0;
        err_short_o   = 1'b0;
        err_overrun_o = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!cs_n_i) begin
                    bit_strobe_o = 1'b1;
                    shift_d      = {shift_q[WORD_BITS-2:0], mosi_i};
                    cnt_d        = CW'(1);
                    state_d      = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (cs_n_i) begin
                    err_short_o = 1'b1;
                    cnt_d       = '0;
                    state_d     = RX_IDLE;
                end else begin
                    bit_strobe_o = 1'b1;
                    shift_d      = {shift_q[WORD_BITS-2:0], mosi_i};
                    cnt_d        = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) state_d = RX_EXEC;
                end
            end
            RX_EXEC: begin
                // A bit clocked during the decode cycle is already past the word.
                word_valid_o  = 1'b1;
                err_overrun_o = !cs_n_i;
                state_d       = RX_DONE;
            end
            RX_DONE: begin
                if (cs_n_i) state_d = RX_IDLE;
                else        err_overrun_o = 1'b1;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign word_o = shift_q;

endmodule

// File: rtl/audio_config_controller.sv
// Audio configuration controller: SPI decode into shadow registers, committed to
// active registers at I2S frame boundaries. AUDIO_CFG_READBACK_EN enables MISO readback.
module audio_config_controller
    import audio_cfg_pkg::*;
#(
    parameter int FRAME_LAST_BIT = 33,
    parameter int WORD_BITS      = 16
) (
    input  logic       serial_clk,
    input  logic       reset,
    input  logic       spi_chip_select,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic       i2s_ws,
    input  logic [5:0] i2s_bit_number,
    output logic [7:0] cfg_volume,
    output logic [2:0] cfg_effect_sel,
    output logic       cfg_mute,
    output logic       cfg_bypass,
    output logic       cfg_commit_pulse,
    output logic       cmd_error
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_LAST_BIT);

    logic [WORD_BITS-1:0] rx_word;
    logic                 rx_valid, rx_bit, rx_short, rx_overrun;
    cfg_cmd_t             cmd;

    spi_word_receiver #(
        .WORD_BITS(WORD_BITS)
    ) u_rx (
        .clk_i        (serial_clk),
        .rst_i        (reset),
        .cs_n_i       (spi_chip_select),
        .mosi_i       (spi_mosi),
        .word_o       (rx_word),
        .word_valid_o (rx_valid),
        .bit_strobe_o (rx_bit),
        .err_short_o  (rx_short),
        .err_overrun_o(rx_overrun)
    );

    assign cmd = cfg_cmd_t'(rx_word[15:0]);

    logic [7:0] vol_sh_q, vol_sh_d, vol_act_q, vol_act_d;
    logic [2:0] eff_sh_q, eff_sh_d, eff_act_q, eff_act_d;
    logic       mute_sh_q, mute_sh_d, mute_act_q, mute_act_d;
    logic       byp_sh_q, byp_sh_d, byp_act_q, byp_act_d;
    logic       pending_q, pending_d, pulse_q, pulse_d;
    logic       err_short_q, err_short_d, err_ovr_q, err_ovr_d;
    logic       boundary, wr;

    assign boundary = i2s_ws && (i2s_bit_number == LAST_BIT);
    assign wr       = rx_valid && !cmd.rw;

    always_ff @(posedge serial_clk or posedge reset) begin
        if (reset) begin
            vol_sh_q    <= VOLUME_DEFAULT;
            eff_sh_q    <= EFFECT_DEFAULT;
            mute_sh_q   <= MUTE_DEFAULT;
            byp_sh_q    <= BYPASS_DEFAULT;
            vol_act_q   <= VOLUME_DEFAULT;
            eff_act_q   <= EFFECT_DEFAULT;
            mute_act_q  <= MUTE_DEFAULT;
            byp_act_q   <= BYPASS_DEFAULT;
            pending_q   <= 1'b0;
            pulse_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            vol_sh_q    <= vol_sh_d;
            eff_sh_q    <= eff_sh_d;
            mute_sh_q   <= mute_sh_d;
            byp_sh_q    <= byp_sh_d;
            vol_act_q   <= vol_act_d;
            eff_act_q   <= eff_act_d;
            mute_act_q  <= mute_act_d;
            byp_act_q   <= byp_act_d;
            pending_q   <= pending_d;
            pulse_q     <= pulse_d;
            err_short_q <= err_short_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    always_comb begin
        vol_sh_d    = vol_sh_q;
        eff_sh_d    = eff_sh_q;
        mute_sh_d   = mute_sh_q;
        byp_sh_d    = byp_sh_q;
        vol_act_d   = vol_act_q;
        eff_act_d   = eff_act_q;
        mute_act_d  = mute_act_q;
        byp_act_d   = byp_act_q;
        pending_d   = pending_q;
        pulse_d     = 1'b0;
        err_short_d = err_short_q;
        err_ovr_d   = err_ovr_q;
        if (wr) begin
            case (cmd.addr)
                ADDR_VOLUME:  vol_sh_d = cmd.data[7:0];
                ADDR_EFFECT:  eff_sh_d = cmd.data[2:0];
                ADDR_CONTROL: begin
                    mute_sh_d = cmd.data[0];
                    byp_sh_d  = cmd.data[1];
                end
                ADDR_COMMIT:  pending_d = 1'b1;
                ADDR_ERR_CLR: begin
                    err_short_d = 1'b0;
                    err_ovr_d   = 1'b0;
                end
                default: ;
            endcase
        end
        if (rx_short)   err_short_d = 1'b1;
        if (rx_overrun) err_ovr_d   = 1'b1;
        // Commit uses registered shadow, so a same-cycle write waits a frame.
        if (boundary && pending_q) begin
            vol_act_d  = vol_sh_q;
            eff_act_d  = eff_sh_q;
            mute_act_d = mute_sh_q;
            byp_act_d  = byp_sh_q;
            pulse_d    = 1'b1;
            pending_d  = 1'b0;
        end
    end

    assign cfg_volume       = vol_act_q;
    assign cfg_effect_sel   = eff_act_q;
    assign cfg_mute         = mute_act_q;
    assign cfg_bypass       = byp_act_q;
    assign cfg_commit_pulse = pulse_q;
    assign cmd_error        = err_short_q | err_ovr_q;

    logic unused_data;
    assign unused_data = ^cmd.data[11:8];

`ifdef AUDIO_CFG_READBACK_EN
    logic [15:0] tx_q, tx_d;

    always_ff @(posedge serial_clk or posedge reset) begin
        if (reset) tx_q <= 16'h0000;
        else       tx_q <= tx_d;
    end

    always_comb begin
        tx_d = tx_q;
        if (rx_bit) tx_d = {tx_q[14:0], 1'b0};
        if (rx_valid && cmd.rw) begin
            tx_d = readback_value(cmd.addr, vol_sh_q, eff_sh_q,
                                  mute_sh_q, byp_sh_q,
                                  {pending_q, err_short_q, err_ovr_q});
        end
    end

    assign spi_miso = tx_q[15];
`else
    logic unused_rx_bit;
    assign unused_rx_bit = rx_bit;
    assign spi_miso      = 1'b0;
`endif

endmodule

// File: tb/tb_audio_config_controller.sv
// Directed bench for audio_config_controller: frame-aligned commits, error
// flags, boundary collisions, readback and asynchronous reset.
module tb_audio_config_controller;

    logic       serial_clk;
    logic       reset;
    logic       spi_chip_select;
    logic       spi_mosi;
    logic       spi_miso;
    logic       i2s_ws;
    logic [5:0] i2s_bit_number;
    logic [7:0] cfg_volume;
    logic [2:0] cfg_effect_sel;
    logic       cfg_mute;
    logic       cfg_bypass;
    logic       cfg_commit_pulse;
    logic       cmd_error;

    int total = 0;
    int bad   = 0;
    int fcnt;

`ifdef AUDIO_CFG_READBACK_EN
    localparam logic [15:0] EXP_RB = 16'h0005;
`else
    localparam logic [15:0] EXP_RB = 16'h0000;
`endif

    audio_config_controller dut (
        .serial_clk      (serial_clk),
        .reset           (reset),
        .spi_chip_select (spi_chip_select),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .i2s_ws          (i2s_ws),
        .i2s_bit_number  (i2s_bit_number),
        .cfg_volume      (cfg_volume),
        .cfg_effect_sel  (cfg_effect_sel),
        .cfg_mute        (cfg_mute),
        .cfg_bypass      (cfg_bypass),
        .cfg_commit_pulse(cfg_commit_pulse),
        .cmd_error       (cmd_error)
    );

    initial begin
        serial_clk = 1'b0;
        forever #5 serial_clk = ~serial_clk;
    end

    // Stereo frame of 68 cycles; fcnt 67 is the boundary (ws=1, bit 33).
    initial begin
        fcnt           = 0;
        i2s_ws         = 1'b0;
        i2s_bit_number = 6'd0;
        forever begin
            @(negedge serial_clk);
            fcnt           = (fcnt == 67) ? 0 : fcnt + 1;
            i2s_ws         = (fcnt >= 34);
            i2s_bit_number = 6'(fcnt % 34);
        end
    end

    task automatic tick();
        @(negedge serial_clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] val, input int n,
                        output logic [31:0] rb);
        rb = 32'h0;
        spi_chip_select = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            rb = {rb[30:0], spi_miso};
            tick();
        end
        spi_chip_select = 1'b1;
        spi_mosi = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_fcnt(input int v);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (fcnt != v && k < 200);
        if (fcnt != v) begin
            total++;
            bad++;
            $error("FAIL wait_fcnt: observed %0d expected %0d", fcnt, v);
        end
    endtask

    task automatic count_pulses(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cfg_commit_pulse === 1'b1) c++;
        end
    endtask

    initial begin
        logic [31:0] rb;
        int          np;
        int          k;

        reset           = 1'b1;
        spi_chip_select = 1'b1;
        spi_mosi        = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_vol",   16'(cfg_volume),       16'h0080);
        check("rst_eff",   16'(cfg_effect_sel),   16'h0000);
        check("rst_mute",  16'(cfg_mute),         16'h0001);
        check("rst_byp",   16'(cfg_bypass),       16'h0001);
        check("rst_pulse", 16'(cfg_commit_pulse), 16'h0000);
        check("rst_err",   16'(cmd_error),        16'h0000);
        check("rst_miso",  16'(spi_miso),         16'h0000);

        // Volume write + commit held until the frame boundary.
        send(32'h0040, 16, rb);
        wait_fcnt(0);
        send(32'h3000, 16, rb);
        wait_fcnt(66);
        check("t1_vol_pre",   16'(cfg_volume),       16'h0080);
        check("t1_pulse_pre", 16'(cfg_commit_pulse), 16'h0000);
        tick();
        check("t1_vol_bnd",   16'(cfg_volume),       16'h0080);
        tick();
        check("t1_vol_post",  16'(cfg_volume),       16'h0040);
        check("t1_pulse",     16'(cfg_commit_pulse), 16'h0001);
        count_pulses(136, np);
        check("t1_one_pulse", 16'(np), 16'h0000);

        // Control write without commit stays invisible.
        send(32'h2000, 16, rb);
        count_pulses(136, np);
        check("t2_no_pulse", 16'(np),         16'h0000);
        check("t2_mute",     16'(cfg_mute),   16'h0001);
        check("t2_byp",      16'(cfg_bypass), 16'h0001);

        // Short word raises the error; address 4 clears it.
        send(32'h0001, 9, rb);
        check("t3_err_set", 16'(cmd_error),  16'h0001);
        check("t3_vol",     16'(cfg_volume), 16'h0040);
        send(32'h4000, 16, rb);
        check("t3_err_clr", 16'(cmd_error),  16'h0000);

        // 20-bit frame: first 16 bits decoded, overrun flagged.
        send(32'h0010A, 20, rb);
        check("t4_err_ovr", 16'(cmd_error), 16'h0001);
        wait_fcnt(0);
        send(32'h3000, 16, rb);
        wait_fcnt(0);
        check("t4_vol",   16'(cfg_volume),       16'h0010);
        check("t4_mute",  16'(cfg_mute),         16'h0000);
        check("t4_byp",   16'(cfg_bypass),       16'h0000);
        check("t4_pulse", 16'(cfg_commit_pulse), 16'h0001);
        send(32'h4000, 16, rb);
        check("t4_err_clr", 16'(cmd_error), 16'h0000);

        // Commit EXEC lands on the boundary cycle: next frame commits.
        send(32'h0033, 16, rb);
        wait_fcnt(51);
        send(32'h3000, 16, rb);
        check("t5_vol_hold", 16'(cfg_volume),       16'h0010);
        check("t5_no_pulse", 16'(cfg_commit_pulse), 16'h0000);
        k = 0;
        while (cfg_commit_pulse !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("t5_latency", 16'(k),          16'd67);
        check("t5_vol",     16'(cfg_volume), 16'h0033);

        // Effect write, then readback of address 1 on the following word.
        send(32'h1005, 16, rb);
        wait_fcnt(0);
        send(32'h3000, 16, rb);
        wait_fcnt(0);
        check("t6_eff", 16'(cfg_effect_sel), 16'h0005);
        send(32'h9000, 16, rb);
        send(32'h5000, 16, rb);
        check("t6_readback", rb[15:0], EXP_RB);

        // Error set, then reset asserted mid-word.
        send(32'h0005, 3, rb);
        check("t7_err_pre", 16'(cmd_error), 16'h0001);
        spi_chip_select = 1'b0;
        for (int i = 0; i < 8; i++) begin
            spi_mosi = i[0];
            tick();
        end
        reset = 1'b1;
        #1;
        check("t7_vol",   16'(cfg_volume),       16'h0080);
        check("t7_eff",   16'(cfg_effect_sel),   16'h0000);
        check("t7_mute",  16'(cfg_mute),         16'h0001);
        check("t7_byp",   16'(cfg_bypass),       16'h0001);
        check("t7_pulse", 16'(cfg_commit_pulse), 16'h0000);
        check("t7_err",   16'(cmd_error),        16'h0000);
        check("t7_miso",  16'(spi_miso),         16'h0000);
        spi_chip_select = 1'b1;
        spi_mosi = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        send(32'h0022, 16, rb);
        wait_fcnt(0);
        send(32'h3000, 16, rb);
        wait_fcnt(0);
        check("t7_vol_new", 16'(cfg_volume),     16'h0022);
        check("t7_mute_sh", 16'(cfg_mute),       16'h0001);
        check("t7_eff_sh",  16'(cfg_effect_sel), 16'h0000);
        check("t7_pulse2",  16'(cfg_commit_pulse), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
